pmips_hazard_unit: RTL and testbench
====================================

Name: pmips_hazard_unit

Overview:
- Parametrised pipeline hazard controller for the next-generation 5-stage PMIPS core (IF, ID, EX, MEM, WB).
- Keeps an internal scoreboard of destination registers for instructions in EX, MEM and WB.
- Produces, from that scoreboard:
  - PC / IF/ID hold and ID/EX bubble on data hazards,
  - registered ALU-operand forwarding selects,
  - three-stage flush on a branch taken in MEM,
  - a saturating stall-cycle counter.
- Sits beside the existing Control block and replaces its ad-hoc instruction-compare stall logic.

Parameters:
- RA_W, 3, register-address width (register file depth = 2**RA_W).
- FWD_EN, 1, 1 = forwarding from EX/MEM and MEM/WB; 0 = stall-only resolution.
- ZERO_REG, 1, 1 = register 0 is hard-wired zero and never creates a hazard.
- CNT_W, 16, width of the stall counter.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs  in  RA_W  source register 1 of the ID instruction.
- id_rt  in  RA_W  source register 2 of the ID instruction.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_dst  in  RA_W  final write address of the ID instruction (RegDst already applied).
- id_regwrite  in  1  ID instruction writes the register file.
- id_memread  in  1  ID instruction is a load.
- mem_branch_taken  in  1  branch in MEM is taken (Branch & zero).
- pc_stall  out  1  hold PC.
- ifid_hold  out  1  hold IF/ID.
- idex_bubble  out  1  load a zero bubble into ID/EX.
- flush_ifid  out  1  zero IF/ID.
- flush_idex  out  1  zero ID/EX.
- flush_exmem  out  1  zero EX/MEM control bits.
- ex_fwd_a  out  2  operand-A select for the instruction now in EX: 0 = regfile, 1 = EX/MEM ALU out, 2 = MEM/WB write data.
- ex_fwd_b  out  2  operand-B select, same encoding (applies before the ALUSrc mux).
- stall_count  out  CNT_W  number of stall cycles, saturating.

Behaviour:
- Scoreboard: three entries, sb_ex, sb_mem, sb_wb. Each entry holds {valid, dst, regwrite, memread}.
- An entry is a "writer" when valid & regwrite & !(ZERO_REG & dst==0).
- Match (per used source register): a writer whose dst equals id_rs with id_use_rs, or id_rt with id_use_rt.
- Hazard detection (combinational, only when id_valid):
  - FWD_EN=1: haz = sb_ex writer with memread that matches (load-use).
  - FWD_EN=0: haz = sb_ex or sb_mem writer that matches.
  - sb_wb never hazards: the register file writes on the negative edge, so WB data is readable in ID in the same cycle.
- Stall outputs: stall = haz & !mem_branch_taken. pc_stall = ifid_hold = idex_bubble = stall.
- Flush: flush_ifid = flush_idex = flush_exmem = mem_branch_taken. Flush has priority over stall.
- Posedge update:
  - sb_wb <= sb_mem.
  - sb_mem <= flush ? invalid : sb_ex.
  - sb_ex <= (flush | stall | !id_valid) ? invalid : ID fields.
- Forward selects:
  - Computed in ID and registered into ex_fwd_a / ex_fwd_b on the same edge that loads sb_ex.
  - A match with the sb_ex writer gives 1 (priority, youngest first).
  - Otherwise a match with the sb_mem writer gives 2.
  - Otherwise 0.
  - Forced to 0 on stall, flush, !id_valid, or FWD_EN=0.
- Latency: forward selects are valid exactly in the cycle the consumer occupies EX. A load-use case costs 1 stall cycle; it then forwards with select 2.
- FWD_EN=0 latency: back-to-back RAW costs 2 stall cycles; distance 2 costs 1.
- stall_count: +1 on every posedge where stall=1. Holds at all-ones (no wrap).
- Reset (asynchronous, any time, including mid-stall or mid-flush): all scoreboard entries invalid, ex_fwd_a = ex_fwd_b = 0, stall_count = 0. All combinational outputs become 0 because the entries are invalid.
- Simultaneous cases:
  - mem_branch_taken during a load-use stall: no stall, no count increment, flush wins.
  - Producer in both EX and MEM with the same dst: select 1.

Test Plan:
- FWD_EN=1: "add r1,r2,r3" then "add r4,r1,r1" -> no stall; next cycle ex_fwd_a=1, ex_fwd_b=1.
- FWD_EN=1: producer r5, one independent instruction, then consumer of r5 in rt -> ex_fwd_b=2, ex_fwd_a=0, stall_count unchanged.
- Load r3 then "add r6,r3,r2" -> 1 cycle of pc_stall=ifid_hold=idex_bubble=1, stall_count=1; consumer enters EX with ex_fwd_a=2.
- FWD_EN=0, back-to-back RAW on r2 -> 2 stall cycles, stall_count=2, selects stay 0. Repeat with dst=r0 and ZERO_REG=1 -> 0 stalls.
- Load-use stall asserted with mem_branch_taken=1 in the same cycle -> all flush outputs 1, pc_stall=0, stall_count unchanged; the next cycle shows no hazard from the killed instructions.
- CNT_W=4, force 20 load-use stalls -> stall_count saturates at 15. Assert reset asynchronously mid-stall -> stall_count=0 and outputs 0 before the next edge.

Source files
------------

// File: rtl/pmips_hazard_unit_if.sv
// ID-stage hazard request bundle and the hazard unit's stall/flush/forward responses.
// The pipeline drives the master side and the hazard unit sits on the slave side.
interface pmips_hazard_unit_if #(
  parameter int unsigned RA_W  = 3,
  parameter int unsigned CNT_W = 16
);
  logic            id_valid;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic [RA_W-1:0] id_dst;
  logic            id_regwrite;
  logic            id_memread;
  logic            mem_branch_taken;

  logic             pc_stall;
  logic             ifid_hold;
  logic             idex_bubble;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic [1:0]       ex_fwd_a;
  logic [1:0]       ex_fwd_b;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
           id_regwrite, id_memread, mem_branch_taken,
    input  pc_stall, ifid_hold, idex_bubble, flush_ifid, flush_idex,
           flush_exmem, ex_fwd_a, ex_fwd_b, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
           id_regwrite, id_memread, mem_branch_taken,
    output pc_stall, ifid_hold, idex_bubble, flush_ifid, flush_idex,
           flush_exmem, ex_fwd_a, ex_fwd_b, stall_count
  );
endinterface

// File: rtl/pmips_hazard_unit.sv
// PMIPS 5-stage hazard controller: destination scoreboard for EX/MEM/WB driving
// load-use / RAW stalls, registered forwarding selects, branch flush and a stall counter.
module pmips_hazard_unit #(
  parameter int unsigned RA_W     = 3,
  parameter int unsigned FWD_EN   = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CNT_W    = 16
) (
  input logic                clock,
  input logic                reset,
  pmips_hazard_unit_if.slave hz
);

  localparam logic [1:0] SEL_RF    = 2'd0;
  localparam logic [1:0] SEL_EXMEM = 2'd1;
  localparam logic [1:0] SEL_MEMWB = 2'd2;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] dst;
    logic            regwrite;
    logic            memread;
  } sb_entry_t;

  sb_entry_t        sb_ex;
  sb_entry_t        sb_mem;
  sb_entry_t        sb_wb;
  sb_entry_t        id_entry;
  sb_entry_t        sb_ex_d;
  sb_entry_t        sb_mem_d;

  logic             ex_writer;
  logic             mem_writer;
  logic             ex_hit_a;
  logic             ex_hit_b;
  logic             mem_hit_a;
  logic             mem_hit_b;
  logic             haz;
  logic             stall;
  logic             flush;

  logic [1:0]       fwd_a_d;
  logic [1:0]       fwd_b_d;
  logic [1:0]       fwd_a_q;
  logic [1:0]       fwd_b_q;
  logic [CNT_W-1:0] stall_count_q;

  // WB data is readable in ID through the negedge register-file write, so sb_wb is tracking only.
  logic             unused_sb;
  assign unused_sb = ^{sb_wb, sb_ex.memread};

  function automatic logic is_writer(input sb_entry_t e);
    return e.valid && e.regwrite && !((ZERO_REG != 0) && (e.dst == '0));
  endfunction

  // Per-operand source matches against the older in-flight writers.
  always_comb begin
    ex_writer  = is_writer(sb_ex);
    mem_writer = is_writer(sb_mem);
    ex_hit_a   = ex_writer  && hz.id_use_rs && (sb_ex.dst  == hz.id_rs);
    ex_hit_b   = ex_writer  && hz.id_use_rt && (sb_ex.dst  == hz.id_rt);
    mem_hit_a  = mem_writer && hz.id_use_rs && (sb_mem.dst == hz.id_rs);
    mem_hit_b  = mem_writer && hz.id_use_rt && (sb_mem.dst == hz.id_rt);
  end

  // With forwarding only a load in EX blocks; stall-only waits out both EX and MEM producers.
  always_comb begin
    haz = 1'b0;
    if (hz.id_valid) begin
      if (FWD_EN != 0) begin
        haz = (ex_hit_a || ex_hit_b) && sb_ex.memread;
      end else begin
        haz = ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b;
      end
    end
    flush = hz.mem_branch_taken;
    stall = haz && !flush;
  end

  // Youngest producer wins; selects are dropped whenever the ID instruction does not advance.
  always_comb begin
    fwd_a_d = SEL_RF;
    fwd_b_d = SEL_RF;
    if ((FWD_EN != 0) && hz.id_valid && !stall && !flush) begin
      if (ex_hit_a) begin
        fwd_a_d = SEL_EXMEM;
      end else if (mem_hit_a) begin
        fwd_a_d = SEL_MEMWB;
      end
      if (ex_hit_b) begin
        fwd_b_d = SEL_EXMEM;
      end else if (mem_hit_b) begin
        fwd_b_d = SEL_MEMWB;
      end
    end
  end

  always_comb begin
    id_entry          = '0;
    id_entry.valid    = hz.id_valid;
    id_entry.dst      = hz.id_dst;
    id_entry.regwrite = hz.id_regwrite;
    id_entry.memread  = hz.id_memread;
    sb_ex_d           = (flush || stall || !hz.id_valid) ? sb_entry_t'('0) : id_entry;
    sb_mem_d          = flush ? sb_entry_t'('0) : sb_ex;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sb_ex         <= '0;
      sb_mem        <= '0;
      sb_wb         <= '0;
      fwd_a_q       <= SEL_RF;
      fwd_b_q       <= SEL_RF;
      stall_count_q <= '0;
    end else begin
      sb_ex   <= sb_ex_d;
      sb_mem  <= sb_mem_d;
      sb_wb   <= sb_mem;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      if (stall && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
    end
  end

  assign hz.pc_stall    = stall;
  assign hz.ifid_hold   = stall;
  assign hz.idex_bubble = stall;
  assign hz.flush_ifid  = flush;
  assign hz.flush_idex  = flush;
  assign hz.flush_exmem = flush;
  assign hz.ex_fwd_a    = fwd_a_q;
  assign hz.ex_fwd_b    = fwd_b_q;
  assign hz.stall_count = stall_count_q;

endmodule

// File: tb/tb_pmips_hazard_unit.sv
// Directed bench for pmips_hazard_unit: a forwarding instance (4-bit counter) and a
// stall-only instance, with registered outputs checked through an expectation queue.
module tb_pmips_hazard_unit;

  localparam int unsigned RA_W  = 3;
  localparam int unsigned CNT_A = 4;
  localparam int unsigned CNT_B = 16;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rs;
    logic            use_rs;
    logic [RA_W-1:0] rt;
    logic            use_rt;
    logic [RA_W-1:0] dst;
    logic            rw;
    logic            mr;
  } instr_t;

  typedef struct {
    bit         sel;
    string      tag;
    logic [1:0] fa;
    logic [1:0] fb;
    int         cnt;
  } exp_t;

  localparam instr_t IDLE = '0;

  logic   clock = 1'b0;
  logic   reset;
  instr_t ia;
  instr_t ib;
  logic   br_a;
  logic   br_b;
  exp_t   q[$];
  int     total = 0;
  int     bad   = 0;
  int     cnt_a;

  pmips_hazard_unit_if #(.RA_W(RA_W), .CNT_W(CNT_A)) ifa ();
  pmips_hazard_unit_if #(.RA_W(RA_W), .CNT_W(CNT_B)) ifb ();

  assign ifa.id_valid         = ia.valid;
  assign ifa.id_rs            = ia.rs;
  assign ifa.id_rt            = ia.rt;
  assign ifa.id_use_rs        = ia.use_rs;
  assign ifa.id_use_rt        = ia.use_rt;
  assign ifa.id_dst           = ia.dst;
  assign ifa.id_regwrite      = ia.rw;
  assign ifa.id_memread       = ia.mr;
  assign ifa.mem_branch_taken = br_a;

  assign ifb.id_valid         = ib.valid;
  assign ifb.id_rs            = ib.rs;
  assign ifb.id_rt            = ib.rt;
  assign ifb.id_use_rs        = ib.use_rs;
  assign ifb.id_use_rt        = ib.use_rt;
  assign ifb.id_dst           = ib.dst;
  assign ifb.id_regwrite      = ib.rw;
  assign ifb.id_memread       = ib.mr;
  assign ifb.mem_branch_taken = br_b;

  pmips_hazard_unit #(.RA_W(RA_W), .FWD_EN(1), .ZERO_REG(1), .CNT_W(CNT_A)) dut_a (
    .clock (clock),
    .reset (reset),
    .hz    (ifa)
  );

  pmips_hazard_unit #(.RA_W(RA_W), .FWD_EN(0), .ZERO_REG(1), .CNT_W(CNT_B)) dut_b (
    .clock (clock),
    .reset (reset),
    .hz    (ifb)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic instr_t mk(input int rs, input bit urs, input int rt, input bit urt,
                                input int dst, input bit rw, input bit mr);
    instr_t x;
    x.valid  = 1'b1;
    x.rs     = RA_W'(rs);
    x.use_rs = urs;
    x.rt     = RA_W'(rt);
    x.use_rt = urt;
    x.dst    = RA_W'(dst);
    x.rw     = rw;
    x.mr     = mr;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One ID cycle: drive, check stall/flush before the edge, then pop and check registered outputs.
  task automatic cyc(input bit sel, input instr_t x, input logic br, input logic e_stall,
                     input logic [1:0] e_fa, input logic [1:0] e_fb, input int e_cnt,
                     input string tag);
    exp_t       e;
    logic [2:0] st;
    logic [2:0] fl;
    if (sel) begin
      ib = x; br_b = br; ia = IDLE; br_a = 1'b0;
    end else begin
      ia = x; br_a = br; ib = IDLE; br_b = 1'b0;
    end
    e.sel = sel; e.tag = tag; e.fa = e_fa; e.fb = e_fb; e.cnt = e_cnt;
    q.push_back(e);
    #1;
    if (sel) begin
      st = {ifb.pc_stall, ifb.ifid_hold, ifb.idex_bubble};
      fl = {ifb.flush_ifid, ifb.flush_idex, ifb.flush_exmem};
    end else begin
      st = {ifa.pc_stall, ifa.ifid_hold, ifa.idex_bubble};
      fl = {ifa.flush_ifid, ifa.flush_idex, ifa.flush_exmem};
    end
    chk({tag, ".stall"}, 32'(st), 32'({3{e_stall}}));
    chk({tag, ".flush"}, 32'(fl), 32'({3{br}}));
    @(posedge clock);
    #1;
    if (q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = q.pop_front();
      if (e.sel) begin
        chk({e.tag, ".fwd_a"}, 32'(ifb.ex_fwd_a), 32'(e.fa));
        chk({e.tag, ".fwd_b"}, 32'(ifb.ex_fwd_b), 32'(e.fb));
        chk({e.tag, ".count"}, 32'(ifb.stall_count), 32'(e.cnt));
      end else begin
        chk({e.tag, ".fwd_a"}, 32'(ifa.ex_fwd_a), 32'(e.fa));
        chk({e.tag, ".fwd_b"}, 32'(ifa.ex_fwd_b), 32'(e.fb));
        chk({e.tag, ".count"}, 32'(ifa.stall_count), 32'(e.cnt));
      end
    end
  endtask

  initial begin
    instr_t lw3;
    instr_t use3;
    instr_t x;

    reset = 1'b1;
    ia = IDLE; ib = IDLE; br_a = 1'b0; br_b = 1'b0;
    #12;
    chk("rst.a_count", 32'(ifa.stall_count), 32'd0);
    chk("rst.a_fwd",   32'({ifa.ex_fwd_a, ifa.ex_fwd_b}), 32'd0);
    chk("rst.a_stall", 32'({ifa.pc_stall, ifa.ifid_hold, ifa.idex_bubble}), 32'd0);
    chk("rst.b_count", 32'(ifb.stall_count), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Forwarding instance: EX/MEM and MEM/WB forwarding.
    cyc(0, mk(2, 1, 3, 1, 1, 1, 0), 0, 0, 2'd0, 2'd0, 0, "fw1_prod");
    cyc(0, mk(1, 1, 1, 1, 4, 1, 0), 0, 0, 2'd1, 2'd1, 0, "fw1_cons");
    cyc(0, mk(2, 1, 3, 1, 5, 1, 0), 0, 0, 2'd0, 2'd0, 0, "fw2_prod");
    cyc(0, mk(2, 1, 3, 1, 7, 1, 0), 0, 0, 2'd0, 2'd0, 0, "fw2_indep");
    cyc(0, mk(2, 1, 5, 1, 6, 1, 0), 0, 0, 2'd0, 2'd2, 0, "fw2_cons");

    // Load-use: one stall, then MEM/WB forwarding.
    lw3  = mk(1, 1, 0, 0, 3, 1, 1);
    use3 = mk(3, 1, 2, 1, 6, 1, 0);
    cyc(0, mk(2, 1, 0, 0, 3, 1, 1), 0, 0, 2'd0, 2'd0, 0, "lu_load");
    cyc(0, use3, 0, 1, 2'd0, 2'd0, 1, "lu_stall");
    cyc(0, use3, 0, 0, 2'd2, 2'd0, 1, "lu_fwd");

    // Load into r0 never hazards.
    cyc(0, mk(2, 1, 0, 0, 0, 1, 1), 0, 0, 2'd0, 2'd0, 1, "z_load");
    cyc(0, mk(0, 1, 0, 1, 1, 1, 0), 0, 0, 2'd0, 2'd0, 1, "z_cons");

    // Branch taken during a load-use stall: flush wins, killed load leaves no hazard.
    cyc(0, mk(5, 1, 0, 0, 2, 1, 1), 0, 0, 2'd0, 2'd0, 1, "fl_load");
    cyc(0, mk(2, 1, 2, 1, 3, 1, 0), 1, 0, 2'd0, 2'd0, 1, "fl_kill");
    cyc(0, mk(2, 1, 2, 1, 3, 1, 0), 0, 0, 2'd0, 2'd0, 1, "fl_after");

    // Counter saturation at 15 with a 4-bit counter.
    cnt_a = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(0, lw3, 0, 0, 2'd0, 2'd0, cnt_a, "sat_load");
      cnt_a = (cnt_a < 15) ? cnt_a + 1 : 15;
      cyc(0, use3, 0, 1, 2'd0, 2'd0, cnt_a, "sat_stall");
      cyc(0, use3, 0, 0, 2'd2, 2'd0, cnt_a, "sat_fwd");
    end
    chk("sat.final", 32'(ifa.stall_count), 32'd15);

    // Asynchronous reset in the middle of a stall cycle.
    cyc(0, lw3, 0, 0, 2'd0, 2'd0, 15, "ar_load");
    ia = use3;
    #1;
    chk("ar_pre.stall", 32'(ifa.pc_stall), 32'd1);
    reset = 1'b1;
    #1;
    chk("ar.stall", 32'({ifa.pc_stall, ifa.ifid_hold, ifa.idex_bubble}), 32'd0);
    chk("ar.count", 32'(ifa.stall_count), 32'd0);
    chk("ar.fwd",   32'({ifa.ex_fwd_a, ifa.ex_fwd_b}), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc(0, use3, 0, 0, 2'd0, 2'd0, 0, "ar_after");

    // Stall-only instance: back-to-back costs 2, distance 2 costs 1.
    cyc(1, mk(1, 1, 3, 1, 2, 1, 0), 0, 0, 2'd0, 2'd0, 0, "nf_prod");
    cyc(1, mk(2, 1, 2, 1, 4, 1, 0), 0, 1, 2'd0, 2'd0, 1, "nf_stall1");
    cyc(1, mk(2, 1, 2, 1, 4, 1, 0), 0, 1, 2'd0, 2'd0, 2, "nf_stall2");
    cyc(1, mk(2, 1, 2, 1, 4, 1, 0), 0, 0, 2'd0, 2'd0, 2, "nf_go");
    cyc(1, mk(1, 1, 1, 1, 5, 1, 0), 0, 0, 2'd0, 2'd0, 2, "nf_d2_prod");
    cyc(1, mk(1, 1, 1, 1, 7, 1, 0), 0, 0, 2'd0, 2'd0, 2, "nf_d2_indep");
    cyc(1, mk(5, 1, 3, 1, 1, 1, 0), 0, 1, 2'd0, 2'd0, 3, "nf_d2_stall");
    cyc(1, mk(5, 1, 3, 1, 1, 1, 0), 0, 0, 2'd0, 2'd0, 3, "nf_d2_go");

    // r0 destination, unused source and invalid ID never stall.
    cyc(1, mk(2, 1, 3, 1, 0, 1, 0), 0, 0, 2'd0, 2'd0, 3, "nf_z_prod");
    cyc(1, mk(0, 1, 0, 1, 4, 1, 0), 0, 0, 2'd0, 2'd0, 3, "nf_z_cons1");
    cyc(1, mk(0, 1, 0, 1, 4, 1, 0), 0, 0, 2'd0, 2'd0, 3, "nf_z_cons2");
    cyc(1, mk(4, 0, 1, 1, 6, 1, 0), 0, 0, 2'd0, 2'd0, 3, "nf_unused_rs");
    x = mk(6, 1, 6, 1, 6, 1, 0);
    x.valid = 1'b0;
    cyc(1, x, 0, 0, 2'd0, 2'd0, 3, "nf_invalid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
